// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, a one-entry skid buffer
// in front of decode, and redirect-driven flushing of stale responses.
module fetch_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  pc_stall,
    input  logic                  redirect,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_pc_plus4
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

    logic [1:0]            state_q,       state_d;
    logic [DATA_WIDTH-1:0] req_pc_q,      req_pc_d;
    logic                  id_valid_q,    id_valid_d;
    logic [DATA_WIDTH-1:0] id_instr_q,    id_instr_d;
    logic [DATA_WIDTH-1:0] id_pc_q,       id_pc_d;
    logic [DATA_WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic                  skid_valid_q,  skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_instr_q,  skid_instr_d;
    logic [DATA_WIDTH-1:0] skid_pc_q,     skid_pc_d;
    logic                  accept;

    assign accept = (state_q == S_REQ) && imem_ready;

    // Gated by rst so the request and stall look idle the instant reset asserts.
    assign imem_req  = !rst && (state_q == S_REQ);
    assign pc_stall  = rst || !(accept || redirect);
    assign imem_addr = pc;

    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;

    always_comb begin
        // NOTE: every next-state signal defaults to its register first, so no path infers a latch.
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;

        if (redirect) begin
            id_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            case (state_q)
                S_REQ:          state_d = imem_ready  ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state_d = imem_rvalid ? S_REQ  : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end else begin
            if (id_ready) id_valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        req_pc_d = pc;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (!id_valid_q || id_ready) begin
                            id_valid_d    = 1'b1;
                            id_instr_d    = imem_rdata;
                            id_pc_d       = req_pc_q;
                            id_pc_plus4_d = req_pc_q + FOUR;
                            state_d       = S_REQ;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = req_pc_q;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (id_ready && skid_valid_q) begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = skid_instr_q;
                        id_pc_d       = skid_pc_q;
                        id_pc_plus4_d = skid_pc_q + FOUR;
                        skid_valid_d  = 1'b0;
                        state_d       = S_REQ;
                    end
                end
                default: begin
                    if (imem_rvalid) state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REQ;
            req_pc_q      <= '0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            req_pc_q      <= req_pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all checked
// against a queue-based model of instructions delivered but not yet consumed by decode.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_stall;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    fetch_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_stall   (pc_stall),
        .redirect   (redirect),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_pc_plus4(id_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    // Model: words handed to decode but not yet consumed, oldest first (slot, then skid).
    item_t       pend[$];
    int          out_st;      // 0 none outstanding, 1 live request, 2 stale request
    logic [31:0] req_pc_m;
    int          resp_cnt;    // cycles until the memory model answers (random phase)
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        out_st   = 0;
        req_pc_m = '0;
        resp_cnt = 0;
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance model and PC register.
    task automatic cycle(input logic rd, input logic rdy, input logic rv,
                         input logic [31:0] rdat, input logic idr, input logic [31:0] tgt);
        logic  exp_req;
        logic  acc;
        item_t it;
        @(negedge clk);
        redirect    = rd;
        imem_ready  = rdy;
        imem_rvalid = rv;
        imem_rdata  = rdat;
        id_ready    = idr;
        #1;
        exp_req = (out_st == 0) && (pend.size() < 2);
        acc     = exp_req && rdy;
        chk("imem_req", imem_req, exp_req);
        chk("pc_stall", pc_stall, !(acc || rd));
        chk("id_valid", id_valid, pend.size() > 0);
        if (exp_req) chk("imem_addr", imem_addr, pc);
        if (pend.size() > 0) begin
            chk("id_instr",    id_instr,    pend[0].instr);
            chk("id_pc",       id_pc,       pend[0].pc);
            chk("id_pc_plus4", id_pc_plus4, pend[0].pc + 32'd4);
        end
        @(posedge clk);
        if (rd) begin
            pend.delete();
            if (out_st != 0) out_st = rv ? 0 : 2;
            else if (acc)    out_st = 2;
        end else begin
            if (idr && pend.size() > 0) void'(pend.pop_front());
            if (rv && out_st == 1) begin
                it.instr = rdat;
                it.pc    = req_pc_m;
                pend.push_back(it);
            end
            if (rv)  out_st = 0;
            if (acc) begin
                out_st   = 1;
                req_pc_m = pc;
            end
        end
        if (resp_cnt > 0) resp_cnt--;
        if (acc) resp_cnt = $urandom_range(1, 3);
        #1;
        if (rd)       pc = tgt;
        else if (acc) pc = pc + 32'd4;
    endtask

    initial begin
        rst = 1'b1; pc = 32'h0; redirect = 1'b0; imem_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_pc_stall", pc_stall, 1'b1);
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Basic fetch at pc=0.
        cycle(0, 1, 0, 32'h0, 1, 32'h0);
        cycle(0, 0, 1, 32'h00500093, 1, 32'h0);
        #1;
        chk("basic_valid", id_valid, 1'b1);
        chk("basic_instr", id_instr, 32'h00500093);
        chk("basic_pc", id_pc, 32'h0);
        chk("basic_pc4", id_pc_plus4, 32'h4);

        // Decode stall: second word parks in the skid buffer.
        cycle(0, 1, 0, 32'h0, 0, 32'h0);
        cycle(0, 0, 1, 32'h00A00113, 0, 32'h0);
        repeat (3) cycle(0, 1, 0, 32'h0, 0, 32'h0);
        #1;
        chk("hold_instr", id_instr, 32'h00500093);
        cycle(0, 1, 0, 32'h0, 1, 32'h0);
        #1;
        chk("hold_release_valid", id_valid, 1'b1);
        chk("hold_release_instr", id_instr, 32'h00A00113);
        chk("hold_release_pc", id_pc, 32'h4);
        cycle(0, 0, 0, 32'h0, 1, 32'h0);

        // Redirect while waiting; stale response dropped three cycles later.
        cycle(0, 1, 0, 32'h0, 1, 32'h0);
        cycle(1, 0, 0, 32'h0, 1, 32'h100);
        repeat (2) cycle(0, 1, 0, 32'h0, 1, 32'h0);
        cycle(0, 1, 1, 32'hDEADBEEF, 1, 32'h0);
        #1;
        chk("drop_valid", id_valid, 1'b0);
        chk("drop_req", imem_req, 1'b1);
        chk("drop_new_addr", imem_addr, 32'h100);
        cycle(0, 1, 0, 32'h0, 0, 32'h0);
        cycle(0, 0, 1, 32'h00000013, 0, 32'h0);

        // Redirect coincident with the response.
        cycle(0, 1, 0, 32'h0, 1, 32'h0);
        cycle(1, 0, 1, 32'hBAD0BAD0, 1, 32'h200);
        #1;
        chk("coinc_req", imem_req, 1'b1);
        chk("coinc_valid", id_valid, 1'b0);
        cycle(0, 0, 0, 32'h0, 1, 32'h0);

        // Wrap-around of pc+4.
        cycle(1, 0, 0, 32'h0, 1, 32'hFFFFFFFC);
        cycle(0, 1, 0, 32'h0, 1, 32'h0);
        cycle(0, 0, 1, 32'h00100073, 0, 32'h0);
        #1;
        chk("wrap_pc", id_pc, 32'hFFFFFFFC);
        chk("wrap_pc4", id_pc_plus4, 32'h0);

        // Asynchronous reset between edges while waiting.
        cycle(0, 1, 0, 32'h0, 1, 32'h0);
        @(negedge clk);
        imem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_imem_req", imem_req, 1'b0);
        chk("arst_id_valid", id_valid, 1'b0);
        chk("arst_pc_stall", pc_stall, 1'b1);
        chk("arst_id_instr", id_instr, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        cycle(0, 1, 0, 32'h0, 1, 32'h0);
        #1;
        chk("arst_first_pc", req_pc_m, 32'h4);

        // Random traffic against the model; memory answers only accepted requests.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0,
                  resp_cnt == 1,
                  $urandom,
                  $urandom_range(0, 2) != 0,
                  $urandom & 32'hFFFFFFFC);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of PC, address and instruction paths.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pc  input  DATA_WIDTH  current PC from the PC register stage.
REQ-005 pc_stall  output  1  high = PC register holds; low = PC register loads pc_next.
REQ-006 redirect  input  1  taken branch or jump resolved downstream; flushes fetch.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  DATA_WIDTH  request address.
REQ-009 imem_ready  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid  input  1  response valid; at most one per accepted request, in order.
REQ-011 imem_rdata  input  DATA_WIDTH  response instruction word.
REQ-012 id_valid  output  1  decode-stage slot holds a valid instruction.
REQ-013 id_ready  input  1  decode consumes the slot this cycle.
REQ-014 id_instr, id_pc, id_pc_plus4  output  DATA_WIDTH each  instruction, its address, address+4.

Function
REQ-015 FSM states: REQ (issuing), WAIT (one request outstanding), HOLD (response parked in skid buffer), DROP (discarding stale response).
REQ-016 At most one memory request is outstanding at any time.
REQ-017 REQ: imem_req=1, imem_addr=pc; on imem_ready, latch req_pc=pc and go to WAIT.
REQ-018 WAIT: imem_req=0; stay until imem_rvalid.
REQ-019 WAIT on imem_rvalid, with the output slot empty or consumed this cycle (!id_valid or id_ready): load id_instr=imem_rdata, id_pc=req_pc, id_pc_plus4=req_pc+4, id_valid=1, go to REQ.
REQ-020 WAIT on imem_rvalid, with id_valid=1 and id_ready=0: store the response and req_pc in the skid buffer, go to HOLD.
REQ-021 HOLD: imem_req=0; on id_ready, move skid buffer to the output slot (id_valid stays 1), go to REQ.
REQ-022 Output slot, no other load and no redirect: id_ready with id_valid=1 clears id_valid next cycle. id_ready with id_valid=0 has no effect.
REQ-023 pc_stall = 0 exactly when (state==REQ and imem_ready) or redirect=1; otherwise 1.
REQ-024 id_pc_plus4 uses modulo 2^DATA_WIDTH addition; 0xFFFFFFFC yields 0x00000000.
REQ-025 imem_addr passes pc unmodified; alignment is not checked.
REQ-026 Redirect has priority over all other events. The next cycle, id_valid=0 and the skid buffer is invalid, whatever the id_ready value.
REQ-027 Redirect next state by current state:
- REQ with imem_ready=1 (stale request accepted): DROP.
- REQ with imem_ready=0: REQ.
- WAIT without rvalid: DROP.
- WAIT with rvalid (response discarded): REQ.
- HOLD: REQ.
- DROP without rvalid: DROP.
- DROP with rvalid: REQ.
REQ-028 DROP: imem_req=0; id_* unchanged except as REQ-026; on imem_rvalid, discard and go to REQ.
REQ-029 imem_rvalid in REQ or HOLD is a protocol violation; it is ignored and never corrupts state.
REQ-030 Best-case throughput: one instruction per two cycles (request, response); latency from request acceptance to id_valid = memory latency + 1 cycle.

Reset
REQ-031 While rst=1, and immediately on assertion, the following hold:
- state=REQ
- id_valid=0
- id_instr=id_pc=id_pc_plus4=0
- skid buffer invalid
- imem_req=0
- pc_stall=1
REQ-032 imem_req may assert from the first rising edge after rst deasserts.
REQ-033 Reset mid-transaction abandons any outstanding request. The bench must not return its response.

Verification
REQ-034 Basic fetch. Stimulus: pc=0x0, imem_ready=1, response 0x00500093 one cycle later, id_ready=1. Response: id_valid=1, id_pc=0x0, id_pc_plus4=0x4, id_instr=0x00500093; pc_stall=0 only in the acceptance cycle.
REQ-035 Decode stall. Stimulus: id_ready=0 for 5 cycles while a second response 0x00A00113 arrives. Response: FSM enters HOLD; id_instr holds the first word; on id_ready=1 the second word appears with id_pc=0x4; no request is issued during HOLD.
REQ-036 Redirect while WAIT. Stimulus: redirect, response arrives 3 cycles later. Response: response discarded (DROP → REQ); id_valid=0 throughout; the next request uses the new pc=0x100.
REQ-037 Redirect coincident with imem_rvalid in WAIT. Response: FSM goes directly to REQ; the word never reaches id_instr.
REQ-038 Wrap-around. Stimulus: pc=0xFFFFFFFC. Response: id_pc_plus4=0x00000000.
REQ-039 Async reset asserted mid-WAIT, between clock edges. Response: id_valid=0 and imem_req=0 immediately; after release, the first request uses the current pc.
